// File: rtl/peripheral_syn_ctrl.sv
// Commit-stream sequencer for the peripheral sync snapshot registers: buffers
// DUT commits, numbers them, and presents one per host handshake.
module peripheral_syn_ctrl #(
   parameter int DEPTH = 4,
   parameter int LVLW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            commit_valid,
   input  logic [63:0]     commit_pc,
   input  logic [63:0]     commit_rfdata,
   output logic            dut_stall,
   input  logic            sync_en,
   input  logic            step_mode,
   input  logic            step_req,
   input  logic            host_ack,
   input  logic            ovf_clr,
   output logic [63:0]     dutpc,
   output logic [63:0]     rfData,
   output logic [63:0]     instrcnt,
   output logic            syn_reg1_update,
   output logic            sync_valid,
   output logic            syn_pending,
   output logic            overflow,
   output logic [LVLW-1:0] fifo_level
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Handshake: a snapshot is offered by a one-cycle LOAD pulse, then held in
   // WAIT until host_ack; the DUT side must hold commits while dut_stall is 1.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [127:0]    mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic [LVLW-1:0] level;
   logic [63:0]     cnt;
   logic [63:0]     pc_hold;
   logic [63:0]     rf_hold;
   logic            step_latch;
   logic            full;
   logic            push;
   logic            pop;
   logic [127:0]    head;

   assign full = (level == LVLW'(DEPTH));
   assign push = commit_valid && !full;
   assign pop  = (state == LOAD);
   assign head = mem[rd_ptr];

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if ((level != '0) && sync_en && (!step_mode || step_latch))
                  state_next = LOAD;
         LOAD: state_next = WAIT;
         WAIT: if (host_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Storage carries no reset; emptiness is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {commit_pc, commit_rfdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         level <= level + LVLW'(push) - LVLW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         pc_hold <= '0;
         rf_hold <= '0;
      end else if (pop) begin
         cnt     <= cnt + 64'd1;
         pc_hold <= head[127:64];
         rf_hold <= head[63:0];
      end
   end

   // A drop in the same cycle as ovf_clr keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    overflow <= 1'b0;
      else if (commit_valid && full) overflow <= 1'b1;
      else if (ovf_clr)             overflow <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         step_latch <= 1'b0;
      else if (step_req)
         step_latch <= 1'b1;
      else if ((state == IDLE) && (state_next != IDLE))
         step_latch <= 1'b0;
   end

   // Outside LOAD the counter already equals the last presented number.
   assign dutpc           = (state == LOAD) ? head[127:64] : pc_hold;
   assign rfData          = (state == LOAD) ? head[63:0]   : rf_hold;
   assign instrcnt        = (state == LOAD) ? cnt + 64'd1  : cnt;
   assign syn_reg1_update = (state == LOAD);
   assign sync_valid      = (state == LOAD);
   assign syn_pending     = (state == WAIT);
   assign dut_stall       = full;
   assign fifo_level      = level;

endmodule

// File: tb/tb_peripheral_syn_ctrl.sv
// Bench for peripheral_syn_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_peripheral_syn_ctrl;

   localparam int DEPTH = 4;
   localparam int LVLW  = $clog2(DEPTH + 1);

   logic            clk;
   logic            reset;
   logic            commit_valid;
   logic [63:0]     commit_pc;
   logic [63:0]     commit_rfdata;
   logic            dut_stall;
   logic            sync_en;
   logic            step_mode;
   logic            step_req;
   logic            host_ack;
   logic            ovf_clr;
   logic [63:0]     dutpc;
   logic [63:0]     rfData;
   logic [63:0]     instrcnt;
   logic            syn_reg1_update;
   logic            sync_valid;
   logic            syn_pending;
   logic            overflow;
   logic [LVLW-1:0] fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_cnt = 1'b1;

   peripheral_syn_ctrl #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .commit_valid    (commit_valid),
      .commit_pc       (commit_pc),
      .commit_rfdata   (commit_rfdata),
      .dut_stall       (dut_stall),
      .sync_en         (sync_en),
      .step_mode       (step_mode),
      .step_req        (step_req),
      .host_ack        (host_ack),
      .ovf_clr         (ovf_clr),
      .dutpc           (dutpc),
      .rfData          (rfData),
      .instrcnt        (instrcnt),
      .syn_reg1_update (syn_reg1_update),
      .sync_valid      (sync_valid),
      .syn_pending     (syn_pending),
      .overflow        (overflow),
      .fifo_level      (fifo_level)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: buffered commits, snapshot phase (0 none, 1 pulse, 2 pending)
   logic [127:0] m_q[$];
   int           m_phase;
   bit           m_ovf;
   bit           m_step;
   logic [63:0]  m_cnt;
   logic [63:0]  m_pc;
   logic [63:0]  m_rf;
   logic [127:0] m_e;
   bit           m_full;
   bit           m_start;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_phase = 0;
         m_ovf   = 1'b0;
         m_step  = 1'b0;
         m_cnt   = '0;
         m_pc    = '0;
         m_rf    = '0;
      end else begin
         m_full  = (m_q.size() == DEPTH);
         m_start = (m_phase == 0) && (m_q.size() != 0) && sync_en && (!step_mode || m_step);
         if (m_phase == 1) begin
            m_e   = m_q.pop_front();
            m_pc  = m_e[127:64];
            m_rf  = m_e[63:0];
            m_cnt = m_cnt + 64'd1;
         end
         if (commit_valid && !m_full) m_q.push_back({commit_pc, commit_rfdata});
         if (commit_valid && m_full) m_ovf = 1'b1;
         else if (ovf_clr)           m_ovf = 1'b0;
         if (step_req)     m_step = 1'b1;
         else if (m_start) m_step = 1'b0;
         case (m_phase)
            0: if (m_start) m_phase = 1;
            1: m_phase = 2;
            default: if (host_ack) m_phase = 0;
         endcase
      end
   end

   // scoreboard compare, once per cycle on the falling edge
   always @(negedge clk) begin
      check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      check("dut_stall", 64'(dut_stall), 64'(m_q.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("syn_reg1_update", 64'(syn_reg1_update), 64'(m_phase == 1));
      check("sync_valid", 64'(sync_valid), 64'(m_phase == 1));
      check("syn_pending", 64'(syn_pending), 64'(m_phase == 2));
      check("dutpc", dutpc, (m_phase == 1) ? m_q[0][127:64] : m_pc);
      check("rfData", rfData, (m_phase == 1) ? m_q[0][63:0] : m_rf);
      if (chk_cnt) check("instrcnt", instrcnt, (m_phase == 1) ? m_cnt + 64'd1 : m_cnt);
   end

   // driver tasks: inputs change 2 time units after the rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic commit(input logic [63:0] pc, input logic [63:0] rf);
      commit_valid  = 1'b1;
      commit_pc     = pc;
      commit_rfdata = rf;
      tick(1);
      commit_valid  = 1'b0;
   endtask

   task automatic do_ack();
      tick(2);
      host_ack = 1'b1;
      tick(1);
      host_ack = 1'b0;
   endtask

   task automatic wait_load(input int budget);
      int n = 0;
      while (syn_reg1_update !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check("load_seen", 64'(syn_reg1_update), 64'd1);
   endtask

   task automatic check_load(input logic [63:0] pc, input logic [63:0] rf, input logic [63:0] cnt);
      check("lit_load_pulse", 64'(syn_reg1_update), 64'd1);
      check("lit_dutpc", dutpc, pc);
      check("lit_rfData", rfData, rf);
      check("lit_instrcnt", instrcnt, cnt);
   endtask

   initial begin
      reset = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_rfdata = '0;
      sync_en = 1'b0; step_mode = 1'b0; step_req = 1'b0; host_ack = 1'b0; ovf_clr = 1'b0;
      tick(2);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_instrcnt", instrcnt, 64'd0);
      check("rst_pending", 64'(syn_pending), 64'd0);
      reset = 1'b0;
      tick(1);

      // free-run, back-to-back commits; third arrives during the LOAD cycle
      sync_en = 1'b1;
      commit_valid = 1'b1; commit_pc = 64'h1000; commit_rfdata = 64'hA;
      tick(1);
      commit_pc = 64'h1004; commit_rfdata = 64'hB;
      tick(1);
      check_load(64'h1000, 64'hA, 64'd1);
      check("lit_level_pre_pushpop", 64'(fifo_level), 64'd2);
      commit_pc = 64'h1008; commit_rfdata = 64'hC;
      tick(1);
      commit_valid = 1'b0;
      check("lit_pending", 64'(syn_pending), 64'd1);
      check("lit_level_pushpop", 64'(fifo_level), 64'd2);
      do_ack();
      tick(1);
      check_load(64'h1004, 64'hB, 64'd2);
      tick(1);
      do_ack();
      tick(1);
      check_load(64'h1008, 64'hC, 64'd3);
      tick(1);
      check("lit_hold_instrcnt", instrcnt, 64'd3);
      check("lit_hold_dutpc", dutpc, 64'h1008);
      do_ack();
      tick(1);

      // fill and overflow with sequencing disabled
      sync_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         commit_valid = 1'b1; commit_pc = 64'h2000 + 64'(4 * i); commit_rfdata = 64'h20 + 64'(i);
         tick(1);
         if (i == 3) begin
            check("lit_stall_at_4", 64'(dut_stall), 64'd1);
            check("lit_level_4", 64'(fifo_level), 64'd4);
         end
      end
      commit_valid = 1'b0;
      check("lit_overflow_set", 64'(overflow), 64'd1);
      check("lit_level_full", 64'(fifo_level), 64'd4);
      tick(2);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("lit_overflow_clr", 64'(overflow), 64'd0);
      sync_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_load(4);
         check_load(64'h2000 + 64'(4 * i), 64'h20 + 64'(i), 64'd4 + 64'(i));
         tick(1);
         do_ack();
      end
      tick(1);

      // single-step
      step_mode = 1'b1;
      commit(64'h3000, 64'h31);
      commit(64'h3004, 64'h32);
      tick(3);
      check("lit_step_hold", 64'(syn_reg1_update), 64'd0);
      check("lit_step_level2", 64'(fifo_level), 64'd2);
      for (int i = 0; i < 2; i++) begin
         step_req = 1'b1;
         tick(1);
         step_req = 1'b0;
         check("lit_step_not_yet", 64'(syn_reg1_update), 64'd0);
         tick(1);
         check_load(64'h3000 + 64'(4 * i), 64'h31 + 64'(i), 64'd8 + 64'(i));
         tick(1);
         check("lit_step_level", 64'(fifo_level), 64'd1 - 64'(i));
         do_ack();
         tick(3);
         check("lit_step_idle", 64'(syn_reg1_update), 64'd0);
      end
      step_mode = 1'b0;

      // counter wrap with the counter pinned to all ones
      sync_en = 1'b0;
      commit(64'h5000, 64'h55);
      chk_cnt = 1'b0;
      force dut.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      sync_en = 1'b1;
      tick(1);
      check_load(64'h5000, 64'h55, 64'd0);
      tick(1);
      release dut.cnt;
      do_ack();
      tick(1);

      // reset during WAIT with three entries still queued
      sync_en = 1'b0;
      for (int i = 0; i < 4; i++) commit(64'h6000 + 64'(4 * i), 64'h60 + 64'(i));
      sync_en = 1'b1;
      wait_load(4);
      check_load(64'h6000, 64'h60, 64'd0);
      tick(1);
      check("lit_wait_pending", 64'(syn_pending), 64'd1);
      check("lit_wait_level3", 64'(fifo_level), 64'd3);
      reset = 1'b1;
      #1;
      check("lit_arst_level", 64'(fifo_level), 64'd0);
      check("lit_arst_pending", 64'(syn_pending), 64'd0);
      check("lit_arst_dutpc", dutpc, 64'd0);
      check("lit_arst_rfData", rfData, 64'd0);
      check("lit_arst_instrcnt", instrcnt, 64'd0);
      check("lit_arst_stall", 64'(dut_stall), 64'd0);
      tick(1);
      reset = 1'b0;
      chk_cnt = 1'b1;
      commit(64'h7000, 64'h77);
      tick(1);
      check_load(64'h7000, 64'h77, 64'd1);
      tick(1);
      do_ack();
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/peripheral_syn_ctrl.md
Name: peripheral_syn_ctrl

Overview:
Sequencer that drives the peripheral sync snapshot registers (the 128-bit pc/instrcnt and rfdata capture registers) from the DUT commit stream. Buffers DUT commits in a small FIFO and numbers them with a 64-bit instruction counter. Presents one commit at a time as single-cycle update pulses, then holds off until the host acknowledges the snapshot. Supports free-run, single-step and freeze modes, and back-pressures the DUT when the buffer fills.

Parameters:
DEPTH, 4, commit FIFO entries; power of two, at least 2.
LVLW, $clog2(DEPTH+1), width of fifo_level.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
commit_valid  in  1  DUT commit strobe
commit_pc  in  64  committed pc/dest/wen word
commit_rfdata  in  64  committed register-file write data
dut_stall  out  1  FIFO full; DUT must hold commits
sync_en  in  1  1 = sequencer may start new snapshots
step_mode  in  1  1 = each snapshot needs a step_req
step_req  in  1  single-cycle step pulse from host
host_ack  in  1  host has read the current snapshot
ovf_clr  in  1  clears overflow
dutpc  out  64  pc word to snapshot register 1
rfData  out  64  data word to snapshot register 2
instrcnt  out  64  sequence number of the presented commit
syn_reg1_update  out  1  load pulse for snapshot register 1
sync_valid  out  1  load pulse for snapshot register 2
syn_pending  out  1  snapshot loaded, awaiting host_ack
overflow  out  1  sticky: a commit was dropped
fifo_level  out  LVLW  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all outputs are 0, the FIFO is empty, the internal step latch is 0, state is IDLE and the counter is 0.
- Push: commit_valid=1 with registered level<DEPTH writes {commit_pc, commit_rfdata} at the clock edge.
- Full: commit_valid=1 with level==DEPTH drops the commit and sets overflow. This holds even when a pop happens in the same cycle, because the decision uses the registered level.
- dut_stall equals (level==DEPTH) and is driven from registers.
- overflow clears only on ovf_clr=1 or reset. If ovf_clr and a drop happen in the same cycle, the set wins.
- Step latch: step_req=1 sets the latch in any state. The latch clears when the FSM leaves IDLE.
- FSM state IDLE: go to LOAD when level>0, sync_en=1, and either step_mode=0 or the step latch is set.
- FSM state LOAD: lasts exactly one cycle.
  - syn_reg1_update=1 and sync_valid=1 (decoded from state).
  - dutpc and rfData show the FIFO head.
  - instrcnt shows the counter value plus 1.
  - At the end of the cycle: head pops, counter increments and state goes to WAIT.
  - Outputs dutpc, rfData and instrcnt keep their last values after LOAD.
- FSM state WAIT: syn_pending=1. host_ack=1 returns to IDLE at the next edge. host_ack outside WAIT is ignored.
- sync_en=0 blocks only the IDLE to LOAD transition. LOAD and WAIT always complete.
- Latency: a commit accepted at edge E0 into an empty FIFO in free-run gives state LOAD in the cycle after E1, with the pulses in that cycle. The snapshot registers capture at E2, and syn_pending is 1 from E2.
- Counter wraps from 2^64-1 to 0 with no flag.
- Simultaneous push and pop in LOAD: level stays unchanged. FIFO pointers wrap modulo DEPTH.
- Commits keep being accepted during WAIT and IDLE until the FIFO is full.
- Reset asserted mid-LOAD or mid-WAIT: immediate return to the reset state. Buffered commits are discarded.

Test Plan:
- Free-run: three commits pc=0x1000/0x1004/0x1008, data=0xA/0xB/0xC, host_ack 2 cycles after each syn_pending -> three LOAD pulses in order, instrcnt 1,2,3, LOAD exactly 2 cycles after each acceptance or ack.
- Full/overflow with DEPTH=4 and sync_en=0: six back-to-back commits -> dut_stall=1 after the 4th commit, commits 5 and 6 dropped, overflow=1, fifo_level=4. Then ovf_clr -> overflow=0.
- Single-step with step_mode=1 and two commits queued -> no LOAD until step_req. Each step_req plus host_ack yields exactly one LOAD, and fifo_level goes 2 to 1 to 0.
- Push and pop together: commit_valid asserted in the LOAD cycle with level=2 -> level stays 2 and the FIFO order is preserved.
- Counter wrap: force the counter to 0xFFFF_FFFF_FFFF_FFFF, then one LOAD -> instrcnt=0.
- Reset during WAIT with 3 entries queued -> all outputs 0 and fifo_level=0 asynchronously. After release, the next commit gets instrcnt=1.
